compressor_feeder: RTL

Sequencing controller for a multi-operand compressor datapath. It accepts one column of source bits per handshake, shifts each column into per-row operand registers that drive the compressor's `src*` inputs, and waits a configurable settle time. It then captures the compressor's destination bits and holds them on a valid/ready output port. It replaces free-running bench shift registers with a framed, back-pressured load/capture sequence.

---
 rtl/compressor_pkg.sv | 19 +
 rtl/operand_shifter.sv | 26 ++
 rtl/compressor_feeder.sv | 94 +++++++++
 3 files changed

// File: rtl/compressor_pkg.sv
// rtl/compressor_pkg.sv - shared state type, default sizes and width helper for the compressor feeder
package compressor_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } feeder_state_t;

  localparam int CMP_N_SRC = 27;
  localparam int CMP_SRC_W = 27;
  localparam int CMP_DST_N = 33;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/operand_shifter.sv
// rtl/operand_shifter.sv - per-row operand shift registers feeding the compressor src ports
module operand_shifter
  import compressor_pkg::*;
#(
  parameter int N_SRC = CMP_N_SRC,
  parameter int SRC_W = CMP_SRC_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [N_SRC-1:0]       in_bits,
  output logic [N_SRC*SRC_W-1:0] rows
);

  // Clear wins over shift; each row takes its own column bit as the new LSB.
  always_ff @(posedge clk) begin
    if (clr) begin
      rows <= '0;
    end else if (shift_en) begin
      for (int k = 0; k < N_SRC; k++) begin
        rows[k*SRC_W +: SRC_W] <= {rows[k*SRC_W +: SRC_W-1], in_bits[k]};
      end
    end
  end

endmodule

// File: rtl/compressor_feeder.sv
// rtl/compressor_feeder.sv - framed column loader, settle timer and result capture for a compressor
module compressor_feeder
  import compressor_pkg::*;
#(
  parameter int N_SRC = CMP_N_SRC,
  parameter int SRC_W = CMP_SRC_W,
  parameter int DST_N = CMP_DST_N,
  parameter int LAT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_SRC-1:0]              in_bits,
  output logic [N_SRC*SRC_W-1:0]        cmp_src,
  input  logic [DST_N-1:0]              cmp_dst,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DST_N-1:0]              out_data,
  output logic                          busy,
  output logic [cnt_width(SRC_W)-1:0]   col_cnt
);

  localparam int            CW          = cnt_width(SRC_W);
  localparam logic [CW-1:0] LAST_COL    = CW'(SRC_W - 1);
  localparam logic [3:0]    SETTLE_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam feeder_state_t AFTER_LOAD  = (LAT > 0) ? SETTLE : HOLD;

  feeder_state_t state;
  logic [3:0]    settle_cnt;
  logic          accept;

  // Handshake outputs decode registered state only, so no input-to-ready path exists.
  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != LOAD) || (col_cnt != '0);

  operand_shifter #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_shifter (
    .clk      (clk),
    .clr      (rst),
    .shift_en (accept),
    .in_bits  (in_bits),
    .rows     (cmp_src)
  );

  // Frame sequencer: count columns, wait the settle time, capture once, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      col_cnt    <= '0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (col_cnt == LAST_COL) begin
              col_cnt    <= '0;
              settle_cnt <= SETTLE_INIT;
              state      <= AFTER_LOAD;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        HOLD: begin
          // First HOLD cycle is the capture; valid rises only after it.
          if (!out_valid) begin
            out_data  <= cmp_dst;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
